// File: rtl/remote_update_ctrl.sv
// remote_update_ctrl: factory-image sequencer for the remote-update primitive.
// Writes boot parameters, reads the last-config reason, then reconfigures or parks in DONE.
module remote_update_ctrl #(
    parameter int          CLK_FREQ_MHZ = 125,
    parameter int          RECONFIG_NS  = 250,
    parameter int          NUM_IMAGES   = 4,
    parameter int          ADDR_W       = 24,
    parameter int          WDOG_EN      = 0,
    parameter logic [11:0] WDOG_TIMEOUT = 12'hFFF,
    parameter int          BUSY_TIMEOUT = 4096,
    localparam int         SW           = NUM_IMAGES > 1 ? $clog2(NUM_IMAGES) : 1
) (
    input  logic                       i_clock,
    input  logic                       i_reset_n,
    input  logic                       i_control,
    input  logic [SW-1:0]              i_image_sel,
    input  logic [NUM_IMAGES*ADDR_W-1:0] i_boot_addrs,
    input  logic                       i_req_valid,
    input  logic [SW-1:0]              i_req_image,
    output logic                       o_req_ready,
    output logic [21:0]                o_ru_data_in,
    output logic [2:0]                 o_ru_param,
    output logic                       o_ru_write_param,
    output logic                       o_ru_read_param,
    output logic [1:0]                 o_ru_read_source,
    output logic                       o_ru_reconfig,
    output logic                       o_ru_reset,
    input  logic                       i_ru_busy,
    input  logic [23:0]                i_ru_data_out,
    output logic [4:0]                 o_reason,
    output logic                       o_crc_error,
    output logic                       o_wdog_error,
    output logic                       o_busy_error,
    output logic                       o_bad_image,
    output logic                       o_done
);
    localparam int R  = (CLK_FREQ_MHZ * RECONFIG_NS + 999) / 1000;
    localparam int CW = $clog2((BUSY_TIMEOUT > R ? BUSY_TIMEOUT : R) + 1);

    typedef enum logic [3:0] {
        S_RST, S_SETUP, S_STROBE, S_GAP, S_WAIT, S_LATCH, S_DECIDE, S_PULSE, S_HOLD, S_DONE
    } state_t;

    state_t              r_state, w_next;
    logic [2:0]          r_step, w_tstep, w_after, r_param, w_param;
    logic [21:0]         r_data, w_data;
    logic [CW-1:0]       r_cnt;
    logic [4:0]          r_reason;
    logic                r_crc, r_wdog, r_busy_err, r_bad;
    logic [SW-1:0]       w_idx;
    logic [ADDR_W-1:0]   w_addr;
    logic                w_sel_bad, w_req_ok, w_tmo, w_unused;

    assign w_unused  = ^i_ru_data_out[23:5];
    assign w_sel_bad = 32'(i_image_sel) >= NUM_IMAGES;
    assign w_req_ok  = 32'(i_req_image) < NUM_IMAGES;
    assign w_tmo     = i_ru_busy && r_cnt == CW'(BUSY_TIMEOUT - 1);
    assign w_idx     = r_state == S_DONE ? i_req_image : i_image_sel;

    always_comb begin
        w_addr = '0;
        for (int k = 0; k < NUM_IMAGES; k++)
            if (w_idx == SW'(k)) w_addr = i_boot_addrs[k*ADDR_W +: ADDR_W];
    end

    // Step 0..4 writes, 5 reason read, 6 run-time boot-address rewrite
    assign w_after = r_step == 3'd0 ? 3'd1 :
                     (r_step == 3'd1 && !w_sel_bad) ? 3'd2 :
                     r_step <= 3'd2 ? ((WDOG_EN != 0) ? 3'd3 : 3'd4) : 3'(r_step + 3'd1);
    assign w_tstep = r_state == S_RST ? 3'd0 : r_state == S_DONE ? 3'd6 : w_after;
    assign w_param = w_tstep == 3'd0 ? 3'b001 : w_tstep == 3'd1 ? 3'b110 :
                     w_tstep == 3'd3 ? 3'b010 : w_tstep == 3'd4 ? 3'b011 :
                     w_tstep == 3'd5 ? 3'b111 : 3'b100;
    assign w_data  = w_tstep <= 3'd1 ? 22'd1 : w_tstep == 3'd3 ? 22'(WDOG_TIMEOUT) :
                     w_tstep == 3'd4 ? 22'(WDOG_EN != 0) : w_tstep == 3'd5 ? 22'd0 :
                     22'(w_addr >> 2);

    always_ff @(posedge i_clock or negedge i_reset_n) begin
        if (!i_reset_n) r_state <= S_RST;
        else            r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_RST:    w_next = i_ru_busy ? S_RST : S_SETUP;
            S_SETUP:  w_next = S_STROBE;
            S_STROBE: w_next = S_GAP;
            S_GAP:    w_next = S_WAIT;
            S_WAIT:   w_next = w_tmo ? S_DONE : i_ru_busy ? S_WAIT :
                               r_step == 3'd5 ? S_LATCH : r_step == 3'd6 ? S_PULSE : S_SETUP;
            S_LATCH:  w_next = S_DECIDE;
            S_DECIDE: w_next = (r_reason[3] || r_reason[4] || w_sel_bad || !i_control) ? S_DONE : S_PULSE;
            S_PULSE:  w_next = r_cnt == CW'(R - 1) ? S_HOLD : S_PULSE;
            S_HOLD:   w_next = S_HOLD;
            S_DONE:   w_next = (i_req_valid && w_req_ok) ? S_SETUP : S_DONE;
            default:  w_next = S_RST;
        endcase
    end

    always_comb begin
        o_ru_reset       = r_state == S_RST;
        o_ru_write_param = r_state == S_STROBE && r_step != 3'd5;
        o_ru_read_param  = r_state == S_STROBE && r_step == 3'd5;
        o_ru_reconfig    = r_state == S_PULSE || r_state == S_HOLD;
        o_done           = r_state == S_DONE;
        o_req_ready      = r_state == S_DONE;
    end

    // Counter restarts at STROBE for the busy timeout and at the first PULSE cycle
    always_ff @(posedge i_clock or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_step     <= '0;
            r_param    <= '0;
            r_data     <= '0;
            r_cnt      <= '0;
            r_reason   <= 5'b01011;
            r_crc      <= 1'b0;
            r_wdog     <= 1'b0;
            r_busy_err <= 1'b0;
            r_bad      <= 1'b0;
        end else begin
            if (w_next == S_SETUP) begin
                r_step  <= w_tstep;
                r_param <= w_param;
                r_data  <= w_data;
            end
            r_cnt <= (r_state == S_SETUP || (w_next == S_PULSE && r_state != S_PULSE)) ? '0 : r_cnt + 1'b1;
            if (r_state == S_LATCH) r_reason <= i_ru_data_out[4:0];
            if (r_state == S_WAIT && w_tmo) r_busy_err <= 1'b1;
            if (r_state == S_DECIDE) begin
                r_crc  <= r_crc | r_reason[3];
                r_wdog <= r_wdog | (!r_reason[3] & r_reason[4]);
                r_bad  <= r_bad | (!r_reason[3] & !r_reason[4] & w_sel_bad);
            end
            if (r_state == S_DONE && i_req_valid && !w_req_ok) r_bad <= 1'b1;
        end
    end

    assign o_ru_param       = r_param;
    assign o_ru_data_in     = r_data;
    assign o_ru_read_source = 2'b00;
    assign o_reason         = r_reason;
    assign o_crc_error      = r_crc;
    assign o_wdog_error     = r_wdog;
    assign o_busy_error     = r_busy_err;
    assign o_bad_image      = r_bad;
endmodule

// File: doc/remote_update_ctrl.md
Name: remote_update_ctrl

Overview:
Parametrised boot-image controller for the factory (bootloader) image. It sequences the device remote-update primitive and selects one of NUM_IMAGES application images from a boot-address table. It optionally arms the user watchdog, detects CRC, watchdog and busy-timeout failures, and accepts a run-time reboot request from the host. It sits between the top-level control logic and the remote-update megafunction, which is driven through the ru_* ports.

Parameters:
CLK_FREQ_MHZ, 125, clock frequency in MHz; sets reconfig pulse length
RECONFIG_NS, 250, minimum reconfig high time in ns
NUM_IMAGES, 4, number of application boot slots (1..8)
ADDR_W, 24, flash byte-address width
WDOG_EN, 0, 1 = write timeout value and enable watchdog; 0 = write enable=0
WDOG_TIMEOUT, 12'hFFF, 12-bit watchdog timeout value
BUSY_TIMEOUT, 4096, maximum cycles busy may stay high per access

Ports:
clock  in  1  system clock
reset_n  in  1  asynchronous active-low reset
control  in  1  1 = boot application at power-up; 0 = stay in factory image
image_sel  in  clog2(NUM_IMAGES) (min 1)  slot used at power-up
boot_addrs  in  NUM_IMAGES*ADDR_W  flattened slot table; slot k at [k*ADDR_W +: ADDR_W]
req_valid  in  1  run-time reboot request, sampled only in DONE
req_image  in  clog2(NUM_IMAGES)  slot for run-time request
req_ready  out  1  high only in DONE
ru_data_in  out  22  parameter data
ru_param  out  3  parameter code
ru_write_param  out  1  write strobe
ru_read_param  out  1  read strobe
ru_read_source  out  2  held at 2'b00
ru_reconfig  out  1  reconfigure trigger
ru_reset  out  1  primitive reset
ru_busy  in  1  primitive busy
ru_data_out  in  24  read data
reason  out  5  last-config reason, ru_data_out[4:0]
crc_error  out  1  reason[3] seen
wdog_error  out  1  reason[4] seen
busy_error  out  1  busy timeout occurred
bad_image  out  1  selected slot >= NUM_IMAGES
done  out  1  sequence finished, no reconfig pending

Behaviour:
- Reset (async, reset_n=0):
  - All outputs 0 except ru_reset=1.
  - reason=5'b01011.
  - FSM enters RST.
- RST: hold ru_reset=1 until ru_busy=0, then release ru_reset and go to INIT (all flags cleared).
- Access handshake, 4 states:
  - SETUP: drive ru_param and ru_data_in.
  - STROBE: strobe=1 for exactly one cycle.
  - GAP: strobe=0.
  - WAIT: advance when ru_busy=0.
  - ru_param and ru_data_in are held stable from SETUP through WAIT.
  - Busy counter runs from STROBE. If it reaches BUSY_TIMEOUT: set busy_error=1, go to DONE without reconfig.
- Write list, in order:
  1. param 001, data 1 (CONF_DONE early)
  2. param 110, data 1 (OSC_INT)
  3. param 100, data boot_addrs[slot]>>2 (slot=image_sel)
  4. param 010, data WDOG_TIMEOUT zero-extended (only if WDOG_EN=1)
  5. param 011, data WDOG_EN
- Reason read:
  - param 111, read strobe, wait busy.
  - One cycle later, latch reason=ru_data_out[4:0].
- Decide, in priority order:
  - reason[3] set: crc_error=1, go to DONE.
  - Else reason[4] set: wdog_error=1, go to DONE.
  - Else image_sel>=NUM_IMAGES: bad_image=1, go to DONE. Check is made before step 3; step 3 is skipped.
  - Else control=1: go to PULSE.
  - Else go to DONE.
- PULSE:
  - Drive ru_reconfig=1 for R = ceil(CLK_FREQ_MHZ*RECONFIG_NS/1000) cycles minimum, counted from the first high cycle (125 MHz gives R=32).
  - Then enter HOLD: ru_reconfig stays 1 until reset; done stays 0.
- DONE:
  - done=1, req_ready=1.
  - req_valid=1 with a valid req_image: clear done, rewrite param 100 with that slot's address, then go to PULSE.
  - req_valid=1 with an invalid req_image: set bad_image=1, stay in DONE.
  - Error flags are sticky until reset.
- reset_n asserted in any state: immediate return to RST. Any strobe or reconfig drops asynchronously.
- ru_busy already high when WAIT is entered: wait with the timeout running; it is not an error.

Test Plan:
- reason=5'h00, control=1, image_sel=2, slot2=24'h300000 → writes in order 001/1, 110/1, 100/22'h0C0000, 011/0; ru_reconfig high ≥32 cycles then held; done=0.
- Model returns reason=5'h08 → crc_error=1, done=1, ru_reconfig never asserted.
- WDOG_EN=1, model returns reason=5'h10 → param 010 carries 12'hFFF and 011 carries 1; wdog_error=1; done=1.
- Model holds busy high after the second write → busy_error=1 exactly BUSY_TIMEOUT cycles after STROBE; done=1; no reconfig.
- control=0, reach DONE, pulse req_valid with req_image=1, slot1=24'h200000 → param 100 write of 22'h080000, then reconfig pulse; req_image=5 with NUM_IMAGES=4 → bad_image=1, stays in DONE.
- Drop reset_n during the third write's STROBE → strobe falls the same cycle; after release the sequence restarts at RST and completes correctly.
